// File: rtl/encode_pack.sv
`default_nettype none
// ============================================================================
// Module   : encode_pack
// Brief    : Packs right-aligned variable-length codes (first bit = MSB of the
//            code) into 64-bit output words, stream byte n in fo_data[8n+7:8n].
//            Optional 9-bit end marker compiled in by ENCODE_PACK_ENDMARK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module encode_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        code_valid,
    input  logic [15:0] code_data,
    input  logic [4:0]  code_len,
    input  logic        code_last,
    output logic        code_ready,
    output logic [63:0] fo_data,
    output logic        fo_we,
    input  logic        fo_full,
    output logic        fo_last,
    output logic [3:0]  fo_bytes,
    output logic        done
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
`ifdef ENCODE_PACK_ENDMARK_EN
        S_MARK  = 2'd1,
`endif
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef ENCODE_PACK_ENDMARK_EN
    localparam logic [8:0] c_MARK     = 9'b110000000;
    localparam logic [6:0] c_MARK_LEN = 7'd9;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [79:0] r_buf;
    logic [79:0] w_buf_nxt;
    logic [6:0]  r_cnt;
    logic [6:0]  w_cnt_nxt;

    logic [4:0]  w_eff_len;
    logic [15:0] w_len_mask;
    logic [15:0] w_code_masked;
    logic [79:0] w_code_al;
    logic [79:0] w_buf_shift;
    logic [63:0] w_word;
    logic [3:0]  w_part_bytes;
    logic        w_cnt_ge64;
`ifdef ENCODE_PACK_ENDMARK_EN
    logic [79:0] w_mark_al;
`endif

    // Buffer holds the stream MSB-first: stream bit k lives at r_buf[79-k],
    // and every bit at or beyond cnt is kept zero so appends are a plain OR.
    assign w_eff_len     = (code_len > 5'd16) ? 5'd16 : code_len;
    assign w_len_mask    = 16'hFFFF >> (5'd16 - w_eff_len);
    assign w_code_masked = code_data & w_len_mask;
    assign w_code_al     = ({w_code_masked, 64'd0} << (5'd16 - w_eff_len)) >> r_cnt;
    assign w_buf_shift   = {r_buf[15:0], 64'd0};
    assign w_cnt_ge64    = (r_cnt >= 7'd64);
    assign w_part_bytes  = r_cnt[6:3] + {3'b000, |r_cnt[2:0]};
`ifdef ENCODE_PACK_ENDMARK_EN
    assign w_mark_al     = {c_MARK, 71'd0} >> r_cnt;
`endif

    for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
        assign w_word[8*gi +: 8] = r_buf[79-8*gi -: 8];
    end

    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        code_ready  = 1'b0;
        fo_we       = 1'b0;
        fo_data     = '0;
        fo_last     = 1'b0;
        fo_bytes    = '0;

        case (r_state)
            S_RUN: begin
                if (w_cnt_ge64) begin
                    if (!fo_full) begin
                        fo_we     = 1'b1;
                        fo_data   = w_word;
                        fo_bytes  = 4'd8;
                        w_buf_nxt = w_buf_shift;
                        w_cnt_nxt = r_cnt - 7'd64;
                    end
                end else begin
                    code_ready = 1'b1;
                    if (code_valid) begin
                        w_buf_nxt = r_buf | w_code_al;
                        w_cnt_nxt = r_cnt + {2'b00, w_eff_len};
                        if (code_last) begin
`ifdef ENCODE_PACK_ENDMARK_EN
                            w_state_nxt = S_MARK;
`else
                            w_state_nxt = S_FLUSH;
`endif
                        end
                    end
                end
            end

`ifdef ENCODE_PACK_ENDMARK_EN
            S_MARK: begin
                if (!w_cnt_ge64) begin
                    w_buf_nxt   = r_buf | w_mark_al;
                    w_cnt_nxt   = r_cnt + c_MARK_LEN;
                    w_state_nxt = S_FLUSH;
                end else if (!fo_full) begin
                    fo_we     = 1'b1;
                    fo_data   = w_word;
                    fo_bytes  = 4'd8;
                    w_buf_nxt = w_buf_shift;
                    w_cnt_nxt = r_cnt - 7'd64;
                end
            end
`endif

            S_FLUSH: begin
                if (w_cnt_ge64) begin
                    if (!fo_full) begin
                        fo_we     = 1'b1;
                        fo_data   = w_word;
                        fo_bytes  = 4'd8;
                        w_buf_nxt = w_buf_shift;
                        w_cnt_nxt = r_cnt - 7'd64;
                        // A word that drains the buffer exactly closes the block.
                        if (r_cnt == 7'd64) begin
                            fo_last     = 1'b1;
                            w_state_nxt = S_DONE;
                        end
                    end
                end else if (r_cnt != 7'd0) begin
                    if (!fo_full) begin
                        fo_we       = 1'b1;
                        fo_data     = w_word;
                        fo_bytes    = w_part_bytes;
                        fo_last     = 1'b1;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_state_nxt = S_DONE;
            end

            default: begin
                w_state_nxt = S_RUN;
            end
        endcase

        // Outputs read zero while reset is held, independent of the clock.
        if (!rst) begin
            code_ready = 1'b0;
            fo_we      = 1'b0;
            fo_data    = '0;
            fo_last    = 1'b0;
            fo_bytes   = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_encode_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_encode_pack
// Brief    : Randomised and directed bench for encode_pack against a bit-queue
//            reference model of the output stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encode_pack;

    logic        clk;
    logic        rst;
    logic        code_valid;
    logic [15:0] code_data;
    logic [4:0]  code_len;
    logic        code_last;
    logic        code_ready;
    logic [63:0] fo_data;
    logic        fo_we;
    logic        fo_full;
    logic        fo_last;
    logic [3:0]  fo_bytes;
    logic        done;

    encode_pack dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code_data  (code_data),
        .code_len   (code_len),
        .code_last  (code_last),
        .code_ready (code_ready),
        .fo_data    (fo_data),
        .fo_we      (fo_we),
        .fo_full    (fo_full),
        .fo_last    (fo_last),
        .fo_bytes   (fo_bytes),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ENCODE_PACK_ENDMARK_EN
    localparam int c_EMPTY_WRITES = 1;
`else
    localparam int c_EMPTY_WRITES = 0;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    bit          mq[$];
    bit          ended;
    bit          xfer;
    int          n_writes;
    logic [63:0] last_word;
    logic [3:0]  last_bytes;
    logic        last_flag;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_push(input logic [15:0] d, input int len);
        for (int i = len - 1; i >= 0; i--) mq.push_back(d[i]);
    endtask

    // Called at a falling edge with inputs set; samples just before the rising
    // edge, updates the model, and returns at the next falling edge.
    task automatic step();
        int          sz;
        int          n;
        logic [63:0] w;
        #4;
        sz   = mq.size();
        xfer = code_valid && code_ready;
        if (!ended) begin
            check_eq("ready", code_ready, sz < 64);
            check_eq("we_when_full_word", fo_we, (sz >= 64) && !fo_full);
            check_eq("done_early", done, 0);
        end else begin
            check_eq("ready_after_last", code_ready, 0);
        end
        if (fo_we) begin
            check_eq("we_vs_full", fo_full, 0);
            n = (sz >= 64) ? 64 : sz;
            w = '0;
            for (int i = 0; i < n; i++) w[8*(i/8) + 7 - (i%8)] = mq[i];
            check_eq("data", fo_data, w);
            check_eq("bytes", fo_bytes, (n + 7) / 8);
            check_eq("last", fo_last, ended && (sz <= 64));
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            n_writes++;
            last_word  = fo_data;
            last_bytes = fo_bytes;
            last_flag  = fo_last;
        end else begin
            check_eq("idle_data", fo_data, 0);
            check_eq("idle_ctl", {fo_bytes, fo_last}, 0);
        end
        if (xfer && !ended) begin
            model_push(code_data, (code_len > 5'd16) ? 16 : int'(code_len));
            if (code_last) begin
`ifdef ENCODE_PACK_ENDMARK_EN
                model_push(16'h0180, 9);
`endif
                ended = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_ctl", {code_ready, fo_we, fo_last, done, fo_bytes}, 0);
        check_eq("rst_data", fo_data, 0);
        mq.delete();
        ended      = 1'b0;
        n_writes   = 0;
        code_valid = 1'b0;
        code_last  = 1'b0;
        fo_full    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send(input logic [15:0] d, input logic [4:0] l, input bit lst,
                        input bit rnd, input bit full);
        int guard = 0;
        code_data = d;
        code_len  = l;
        code_last = lst;
        do begin
            code_valid = !rnd || ($urandom_range(0, 3) != 0) || (guard > 20);
            fo_full    = rnd ? ((guard < 40) && ($urandom_range(0, 3) == 0)) : full;
            step();
            guard++;
        end while (!xfer && guard < 100);
        check_eq("send_accepted", xfer, 1);
        code_valid = 1'b0;
        code_last  = 1'b0;
    endtask

    task automatic finish_block(input bit rnd);
        int guard = 0;
        code_valid = 1'b0;
        code_last  = 1'b0;
        while (!done && guard < 300) begin
            fo_full = rnd && ($urandom_range(0, 3) == 0);
            if (rnd) begin
                code_valid = $urandom_range(0, 1);
                code_data  = 16'($urandom);
                code_len   = 5'($urandom_range(0, 31));
            end
            step();
            guard++;
        end
        check_eq("done_reached", done, 1);
        check_eq("residue_bits", mq.size(), 0);
        code_valid = 1'b1;
        step();
        check_eq("done_sticky", done, 1);
        code_valid = 1'b0;
        fo_full    = 1'b0;
    endtask

    task automatic seq_r32(input int upto);
        for (int k = 1; k <= upto; k++) send(16'(k), 5'd8, k == 8, 0, 0);
    endtask

    task automatic random_block(input int ncodes);
        for (int k = 0; k < ncodes; k++)
            send(16'($urandom), 5'($urandom_range(0, 31)), k == ncodes - 1, 1, 0);
        finish_block(1);
    endtask

    initial begin
        rst        = 1'b0;
        code_valid = 1'b0;
        code_data  = '0;
        code_len   = '0;
        code_last  = 1'b0;
        fo_full    = 1'b0;
        ended      = 1'b0;
        n_writes   = 0;
        last_word  = '0;
        last_bytes = '0;
        last_flag  = 1'b0;
        @(negedge clk);
        do_reset();

        // Eight byte codes forming exactly one word.
        seq_r32(8);
`ifndef ENCODE_PACK_ENDMARK_EN
        step();
        check_eq("r32_writes", n_writes, 1);
        check_eq("r32_word", last_word, 64'h0807060504030201);
        check_eq("r32_bytes", last_bytes, 8);
        check_eq("r32_last", last_flag, 1);
        check_eq("r32_done_next", done, 1);
`endif
        finish_block(0);

`ifdef ENCODE_PACK_ENDMARK_EN
        do_reset();
        send(16'h01FF, 5'd9, 1, 0, 0);
        finish_block(0);
        check_eq("r33_writes", n_writes, 1);
        check_eq("r33_word", last_word, 64'h0000_0000_0000_E0FF);
        check_eq("r33_bytes", last_bytes, 3);
        check_eq("r33_last", last_flag, 1);
`endif

        // Empty block: a single zero-length last code.
        do_reset();
        send(16'hFFFF, 5'd0, 1, 0, 0);
        finish_block(0);
        check_eq("empty_writes", n_writes, c_EMPTY_WRITES);

        // Back-pressure on a full word.
        do_reset();
        for (int k = 0; k < 4; k++) send(16'hAAAA, 5'd16, 0, 0, 1);
        check_eq("r34_ready_held", code_ready, 0);
        check_eq("r34_we_held", fo_we, 0);
        step();
        fo_full = 1'b0;
        step();
        check_eq("r34_writes", n_writes, 1);
        check_eq("r34_word", last_word, 64'hAAAA_AAAA_AAAA_AAAA);
        check_eq("r34_ready_back", code_ready, 1);
        send(16'h0000, 5'd0, 1, 0, 0);
        finish_block(0);

        // Oversized length clamps to 16.
        do_reset();
        send(16'hF00F, 5'd20, 1, 0, 0);
        finish_block(0);
        check_eq("r35_low_bytes", last_word[15:0], 16'h0FF0);

        // Reset mid-stream, then the same block again.
        do_reset();
        seq_r32(5);
        do_reset();
        seq_r32(8);
        finish_block(0);
`ifndef ENCODE_PACK_ENDMARK_EN
        check_eq("r36_writes", n_writes, 1);
        check_eq("r36_word", last_word, 64'h0807060504030201);
`endif

        for (int b = 0; b < 10; b++) begin
            do_reset();
            random_block($urandom_range(1, 40));
        end

        // Random partial block abandoned by reset.
        do_reset();
        for (int k = 0; k < 12; k++) send(16'($urandom), 5'($urandom_range(0, 31)), 0, 1, 0);
        do_reset();
        random_block(25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
